// File: rtl/inst_cache_responder_pkg.sv
// Shared types and helpers for the instruction-cache responder.
// Holds the FSM state encoding, line geometry and the line-buffer word insert helper.
package inst_cache_responder_pkg;

    typedef enum logic [2:0] {
        ICR_IDLE   = 3'd0,
        ICR_LOOKUP = 3'd1,
        ICR_MISS   = 3'd2,
        ICR_REFILL = 3'd3,
        ICR_RESP   = 3'd4
    } icr_state_e;

    localparam int SINGLE_WORD = 32;
    localparam int LINE_W      = 128;

    function automatic logic [LINE_W-1:0] line_insert(
        input logic [LINE_W-1:0]      line,
        input logic [1:0]             word,
        input logic [SINGLE_WORD-1:0] data
    );
        logic [LINE_W-1:0] res;
        res = line;
        case (word)
            2'd0:    res[31:0]   = data;
            2'd1:    res[63:32]  = data;
            2'd2:    res[95:64]  = data;
            2'd3:    res[127:96] = data;
            default: res = line;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Tag+data array for the instruction cache: one synchronous read port, one write port.
module icache_line_ram
    import inst_cache_responder_pkg::*;
#(
    parameter int LINE_NUM = 64,
    parameter int TAG_W    = 22,
    localparam int INDEX_W = $clog2(LINE_NUM),
    localparam int ENTRY_W = TAG_W + LINE_W
) (
    input  logic               clk,
    input  logic               rd_en,
    input  logic [INDEX_W-1:0] rd_index,
    output logic [ENTRY_W-1:0] rd_entry,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [ENTRY_W-1:0] wr_entry
);

    logic [ENTRY_W-1:0] mem_r [LINE_NUM];

    // Array write and registered read; contents are qualified by the valid flops in the top.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_index] <= wr_entry;
        end
        if (rd_en) begin
            rd_entry <= mem_r[rd_index];
        end
    end

endmodule

// File: rtl/inst_cache_responder.sv
// Direct-mapped instruction cache responder: pipelined hits, single outstanding miss
// with a four-word refill burst into a line buffer.
module inst_cache_responder
    import inst_cache_responder_pkg::*;
#(
    parameter int LINE_NUM = 64,
    parameter int TAG_W    = 22,
    localparam int INDEX_W = $clog2(LINE_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_req,
    input  logic               inst_wr,
    input  logic [1:0]         inst_size,
    input  logic [INDEX_W-1:0] inst_index,
    input  logic [31:0]        inst_wdata,
    output logic               inst_index_ok,
    input  logic [TAG_W-1:0]   inst_ptag,
    input  logic               inst_uncached,
    input  logic               inst_cancel,
    output logic [127:0]       inst_rdata,
    output logic               inst_data_ok,
    output logic               rd_req,
    output logic [31:0]        rd_addr,
    input  logic               rd_rdy,
    input  logic               ret_valid,
    input  logic               ret_last,
    input  logic [31:0]        ret_data
);

    icr_state_e                 state_r, state_s;
    logic [INDEX_W-1:0]         idx_r;
    logic [TAG_W-1:0]           tag_r;
    logic                       uncached_r;
    logic [1:0]                 cnt_r;
    logic [LINE_W-1:0]          line_r;
    logic                       dropped_r;
    logic [LINE_NUM-1:0]        valid_r;
    logic [TAG_W+LINE_W-1:0]    ram_entry_s;
    logic [LINE_W-1:0]          line_next_s;
    logic                       hit_s, accept_s, array_wr_s;
    logic                       index_ok_s, data_ok_s, rd_req_s;
    logic [127:0]               rdata_s;
    logic                       miss_latch_s, cnt_clr_s, beat_s, fill_done_s;
    logic                       drop_set_s, drop_clr_s;
    logic                       unused_s;

    assign unused_s    = ^{inst_wr, inst_size, inst_wdata};
    assign hit_s       = valid_r[idx_r] && (ram_entry_s[TAG_W+LINE_W-1:LINE_W] == inst_ptag)
                         && !inst_uncached;
    assign accept_s    = inst_req && index_ok_s;
    assign line_next_s = line_insert(line_r, cnt_r, ret_data);
    assign array_wr_s  = fill_done_s && !uncached_r;

    icache_line_ram #(.LINE_NUM(LINE_NUM), .TAG_W(TAG_W)) u_line_ram (
        .clk      (clk),
        .rd_en    (accept_s),
        .rd_index (inst_index),
        .rd_entry (ram_entry_s),
        .wr_en    (array_wr_s),
        .wr_index (idx_r),
        .wr_entry ({tag_r, line_next_s})
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ICR_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and handshake decode; cancel takes priority over hit/miss in LOOKUP.
    always_comb begin
        state_s      = state_r;
        index_ok_s   = 1'b0;
        data_ok_s    = 1'b0;
        rdata_s      = 128'd0;
        rd_req_s     = 1'b0;
        miss_latch_s = 1'b0;
        cnt_clr_s    = 1'b0;
        beat_s       = 1'b0;
        fill_done_s  = 1'b0;
        drop_set_s   = 1'b0;
        drop_clr_s   = 1'b0;
        if (rst) begin
            state_s = ICR_IDLE;
        end else begin
            case (state_r)
                ICR_IDLE: begin
                    index_ok_s = 1'b1;
                    state_s    = inst_req ? ICR_LOOKUP : ICR_IDLE;
                end
                ICR_LOOKUP: begin
                    if (inst_cancel) begin
                        index_ok_s = 1'b1;
                        state_s    = inst_req ? ICR_LOOKUP : ICR_IDLE;
                    end else if (hit_s) begin
                        data_ok_s  = 1'b1;
                        rdata_s    = ram_entry_s[LINE_W-1:0];
                        index_ok_s = 1'b1;
                        state_s    = inst_req ? ICR_LOOKUP : ICR_IDLE;
                    end else begin
                        miss_latch_s = 1'b1;
                        state_s      = ICR_MISS;
                    end
                end
                ICR_MISS: begin
                    rd_req_s = 1'b1;
                    if (rd_rdy) begin
                        cnt_clr_s  = 1'b1;
                        drop_set_s = inst_cancel;
                        state_s    = ICR_REFILL;
                    end else if (inst_cancel) begin
                        state_s = ICR_IDLE;
                    end else begin
                        state_s = ICR_MISS;
                    end
                end
                ICR_REFILL: begin
                    beat_s     = ret_valid;
                    drop_set_s = inst_cancel;
                    if (ret_valid && ret_last) begin
                        fill_done_s = 1'b1;
                        state_s     = ICR_RESP;
                    end else begin
                        state_s = ICR_REFILL;
                    end
                end
                ICR_RESP: begin
                    data_ok_s  = !dropped_r && !inst_cancel;
                    rdata_s    = line_r;
                    drop_clr_s = 1'b1;
                    state_s    = ICR_IDLE;
                end
                default: state_s = ICR_IDLE;
            endcase
        end
    end

    // Request context, refill buffer and valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r      <= '0;
            tag_r      <= '0;
            uncached_r <= 1'b0;
            cnt_r      <= 2'd0;
            line_r     <= 128'd0;
            dropped_r  <= 1'b0;
            valid_r    <= '0;
        end else begin
            if (accept_s) idx_r <= inst_index;
            if (miss_latch_s) begin
                tag_r      <= inst_ptag;
                uncached_r <= inst_uncached;
            end
            if (cnt_clr_s)   cnt_r <= 2'd0;
            else if (beat_s) cnt_r <= cnt_r + 2'd1;
            if (beat_s) line_r <= line_next_s;
            if (drop_clr_s)      dropped_r <= 1'b0;
            else if (drop_set_s) dropped_r <= 1'b1;
            if (array_wr_s) valid_r[idx_r] <= 1'b1;
        end
    end

    assign inst_index_ok = index_ok_s;
    assign inst_data_ok  = data_ok_s;
    assign inst_rdata    = rdata_s;
    assign rd_req        = rd_req_s;
    assign rd_addr       = rd_req_s ? {tag_r, idx_r, 4'b0000} : 32'd0;

endmodule

// File: tb/tb_inst_cache_responder.sv
// Directed self-checking bench for inst_cache_responder: misses, hit streams,
// uncached fills, cancels and reset during refill.
module tb_inst_cache_responder;

    logic         clk = 1'b0;
    logic         rst, inst_req, inst_wr;
    logic [1:0]   inst_size;
    logic [5:0]   inst_index;
    logic [31:0]  inst_wdata;
    logic         inst_index_ok;
    logic [21:0]  inst_ptag;
    logic         inst_uncached, inst_cancel;
    logic [127:0] inst_rdata;
    logic         inst_data_ok, rd_req;
    logic [31:0]  rd_addr;
    logic         rd_rdy, ret_valid, ret_last;
    logic [31:0]  ret_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_cache_responder dut (
        .clk(clk), .rst(rst), .inst_req(inst_req), .inst_wr(inst_wr),
        .inst_size(inst_size), .inst_index(inst_index), .inst_wdata(inst_wdata),
        .inst_index_ok(inst_index_ok), .inst_ptag(inst_ptag),
        .inst_uncached(inst_uncached), .inst_cancel(inst_cancel),
        .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid),
        .ret_last(ret_last), .ret_data(ret_data)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept idx in IDLE, then present the MMU result; returns in the cycle after LOOKUP.
    task automatic start_miss(input logic [5:0] idx, input logic [21:0] ptag, input logic unc);
        inst_req = 1'b1; inst_index = idx;
        tick();
        inst_req = 1'b0; inst_ptag = ptag; inst_uncached = unc;
        tick();
    endtask

    // Drive a four-beat return burst, asserting inst_cancel on beat cancel_beat.
    task automatic drive_burst(input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3,
                               input int cancel_beat);
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < 4; i++) begin
            ret_valid = 1'b1; ret_last = (i == 3); ret_data = w[i];
            inst_cancel = (i == cancel_beat);
            tick();
        end
        ret_valid = 1'b0; ret_last = 1'b0; inst_cancel = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        #1;
        checks++; if (inst_index_ok !== 1'b0) begin errors++; $display("FAIL reset_index_ok got %b want 0", inst_index_ok); end
        checks++; if (inst_data_ok !== 1'b0 || rd_req !== 1'b0) begin errors++; $display("FAIL reset_outputs data_ok %b rd_req %b want 0 0", inst_data_ok, rd_req); end
        checks++; if (rd_addr !== 32'd0 || inst_rdata !== 128'd0) begin errors++; $display("FAIL reset_data rd_addr %h rdata %h want 0", rd_addr, inst_rdata); end
        rst = 1'b0;
        #1;
        checks++; if (inst_index_ok !== 1'b1) begin errors++; $display("FAIL idle_index_ok got %b want 1", inst_index_ok); end
    endtask

    task automatic test_cold_miss;
        inst_req = 1'b1; inst_index = 6'd5;
        tick();
        inst_req = 1'b0; inst_ptag = 22'h12345; inst_uncached = 1'b0;
        #1;
        checks++; if (inst_data_ok !== 1'b0 || inst_index_ok !== 1'b0) begin errors++; $display("FAIL miss_lookup data_ok %b index_ok %b want 0 0", inst_data_ok, inst_index_ok); end
        tick();
        checks++; if (rd_req !== 1'b1 || rd_addr !== 32'h048D_1450) begin errors++; $display("FAIL cold_rd_req rd_req %b addr %h want 1 048d1450", rd_req, rd_addr); end
        rd_rdy = 1'b1;
        tick();
        rd_rdy = 1'b0;
        #1;
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL refill_rd_req got %b want 0", rd_req); end
        drive_burst(32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333, -1);
        #1;
        checks++; if (inst_data_ok !== 1'b1 || inst_index_ok !== 1'b0) begin errors++; $display("FAIL cold_resp data_ok %b index_ok %b want 1 0", inst_data_ok, inst_index_ok); end
        checks++; if (inst_rdata !== 128'hA3A3_3333_A2A2_2222_A1A1_1111_A0A0_0000) begin errors++; $display("FAIL cold_rdata got %h", inst_rdata); end
        tick();
        checks++; if (inst_data_ok !== 1'b0 || inst_index_ok !== 1'b1) begin errors++; $display("FAIL after_resp data_ok %b index_ok %b want 0 1", inst_data_ok, inst_index_ok); end
    endtask

    task automatic test_hit_stream;
        int pulses = 0;
        int reqs   = 0;
        inst_req = 1'b1; inst_index = 6'd5;
        for (int c = 0; c < 6; c++) begin
            inst_req = (c < 4); inst_ptag = 22'h12345; inst_uncached = 1'b0;
            #1;
            if (c < 4) begin
                checks++; if (inst_index_ok !== 1'b1) begin errors++; $display("FAIL hit_index_ok cycle %0d got %b want 1", c, inst_index_ok); end
            end
            if (inst_data_ok === 1'b1) begin
                pulses++;
                checks++; if (inst_rdata !== 128'hA3A3_3333_A2A2_2222_A1A1_1111_A0A0_0000) begin errors++; $display("FAIL hit_rdata cycle %0d got %h", c, inst_rdata); end
            end
            if (rd_req === 1'b1) reqs++;
            checks++; if (inst_data_ok !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL hit_data_ok cycle %0d got %b", c, inst_data_ok); end
            tick();
        end
        checks++; if (pulses != 4 || reqs != 0) begin errors++; $display("FAIL hit_stream pulses %0d rd_reqs %0d want 4 0", pulses, reqs); end
    endtask

    task automatic test_uncached;
        start_miss(6'd5, 22'h12345, 1'b1);
        checks++; if (rd_req !== 1'b1 || rd_addr !== 32'h048D_1450) begin errors++; $display("FAIL unc_rd_req rd_req %b addr %h want 1 048d1450", rd_req, rd_addr); end
        rd_rdy = 1'b1; tick(); rd_rdy = 1'b0;
        drive_burst(32'hB0, 32'hB1, 32'hB2, 32'hB3, -1);
        #1;
        checks++; if (inst_data_ok !== 1'b1 || inst_rdata !== {32'hB3, 32'hB2, 32'hB1, 32'hB0}) begin errors++; $display("FAIL unc_resp data_ok %b rdata %h", inst_data_ok, inst_rdata); end
        tick();
        inst_req = 1'b1; inst_index = 6'd5; tick();
        inst_req = 1'b0; inst_uncached = 1'b0; #1;
        checks++; if (inst_data_ok !== 1'b1 || inst_rdata !== 128'hA3A3_3333_A2A2_2222_A1A1_1111_A0A0_0000) begin errors++; $display("FAIL unc_no_overwrite data_ok %b rdata %h", inst_data_ok, inst_rdata); end
        tick();
        start_miss(6'd7, 22'h00ABC, 1'b1);
        rd_rdy = 1'b1; tick(); rd_rdy = 1'b0;
        drive_burst(32'hC0, 32'hC1, 32'hC2, 32'hC3, -1);
        tick();
        start_miss(6'd7, 22'h00ABC, 1'b0);
        checks++; if (rd_req !== 1'b1 || rd_addr !== 32'h002A_F070) begin errors++; $display("FAIL unc_still_miss rd_req %b addr %h want 1 002af070", rd_req, rd_addr); end
        rd_rdy = 1'b1; tick(); rd_rdy = 1'b0;
        drive_burst(32'hC0, 32'hC1, 32'hC2, 32'hC3, -1);
        tick();
    endtask

    task automatic test_cancel_refill;
        start_miss(6'd63, 22'h3FFFFF, 1'b0);
        checks++; if (rd_addr !== 32'hFFFF_FFF0) begin errors++; $display("FAIL max_rd_addr got %h want fffffff0", rd_addr); end
        rd_rdy = 1'b1; tick(); rd_rdy = 1'b0;
        drive_burst(32'hE0, 32'hE1, 32'hE2, 32'hE3, 1);
        #1;
        checks++; if (inst_data_ok !== 1'b0) begin errors++; $display("FAIL cancel_refill_data_ok got %b want 0", inst_data_ok); end
        tick();
        inst_req = 1'b1; inst_index = 6'd63; tick();
        inst_req = 1'b0; inst_ptag = 22'h3FFFFF; inst_uncached = 1'b0; #1;
        checks++; if (inst_data_ok !== 1'b1 || inst_rdata !== {32'hE3, 32'hE2, 32'hE1, 32'hE0}) begin errors++; $display("FAIL cancel_refill_hit data_ok %b rdata %h", inst_data_ok, inst_rdata); end
        tick();
    endtask

    task automatic test_cancel_lookup;
        start_miss(6'd9, 22'h00009, 1'b0);
        rd_rdy = 1'b1; tick(); rd_rdy = 1'b0;
        drive_burst(32'hD0, 32'hD1, 32'hD2, 32'hD3, -1);
        tick();
        inst_req = 1'b1; inst_index = 6'd5; tick();
        inst_index = 6'd9; inst_cancel = 1'b1; inst_ptag = 22'h12345; inst_uncached = 1'b0; #1;
        checks++; if (inst_data_ok !== 1'b0 || inst_index_ok !== 1'b1) begin errors++; $display("FAIL cancel_lookup data_ok %b index_ok %b want 0 1", inst_data_ok, inst_index_ok); end
        tick();
        inst_req = 1'b0; inst_cancel = 1'b0; inst_ptag = 22'h00009; #1;
        checks++; if (inst_data_ok !== 1'b1 || inst_rdata !== {32'hD3, 32'hD2, 32'hD1, 32'hD0}) begin errors++; $display("FAIL post_flush_hit data_ok %b rdata %h", inst_data_ok, inst_rdata); end
        tick();
        checks++; if (inst_index_ok !== 1'b1 || inst_data_ok !== 1'b0) begin errors++; $display("FAIL post_flush_idle index_ok %b data_ok %b want 1 0", inst_index_ok, inst_data_ok); end
    endtask

    task automatic test_reset_mid_refill;
        start_miss(6'd20, 22'h00500, 1'b0);
        rd_rdy = 1'b1; tick(); rd_rdy = 1'b0;
        ret_valid = 1'b1; ret_data = 32'hF0; tick();
        ret_data = 32'hF1; tick();
        ret_valid = 1'b0; rst = 1'b1; #1;
        checks++; if (inst_index_ok !== 1'b0) begin errors++; $display("FAIL midrst_index_ok got %b want 0", inst_index_ok); end
        tick();
        rst = 1'b0; #1;
        checks++; if (rd_req !== 1'b0 || inst_index_ok !== 1'b1) begin errors++; $display("FAIL midrst_idle rd_req %b index_ok %b want 0 1", rd_req, inst_index_ok); end
        start_miss(6'd5, 22'h12345, 1'b0);
        checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL midrst_line_invalid rd_req %b want 1", rd_req); end
        inst_cancel = 1'b1; #1;
        checks++; if (rd_req !== 1'b1) begin errors++; $display("FAIL miss_cancel_cycle rd_req %b want 1", rd_req); end
        tick();
        inst_cancel = 1'b0; #1;
        checks++; if (rd_req !== 1'b0 || inst_index_ok !== 1'b1) begin errors++; $display("FAIL miss_cancel_idle rd_req %b index_ok %b want 0 1", rd_req, inst_index_ok); end
    endtask

    initial begin
        rst = 1'b1; inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'b11;
        inst_index = 6'd0; inst_wdata = 32'd0; inst_ptag = 22'd0;
        inst_uncached = 1'b0; inst_cancel = 1'b0; rd_rdy = 1'b0;
        ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'd0;
        test_reset();
        test_cold_miss();
        test_hit_stream();
        test_uncached();
        test_cancel_refill();
        test_cancel_lookup();
        test_reset_mid_refill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
